// File: rtl/lbp_scan_ctrl_pkg.sv
// Shared definitions for the LBP raster-scan controller: FSM encoding and
// default image geometry.
package lbp_scan_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SCAN  = 2'd1,
    ST_FLUSH = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  localparam int unsigned DEF_IMG_W  = 128;
  localparam int unsigned DEF_IMG_H  = 128;
  localparam int unsigned DEF_ADDR_W = 14;

  localparam int unsigned COL_W = $clog2(DEF_IMG_W);
  localparam int unsigned ROW_W = $clog2(DEF_IMG_H);

endpackage

// File: rtl/lbp_scan_ctrl_up_counter.sv
// Generic up counter with synchronous clear (clear wins over enable).
module up_counter #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic         clr,
  output logic [W-1:0] count
);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      count <= '0;
    else if (clr)
      count <= '0;
    else if (en)
      count <= count + W'(1);
  end

endmodule

// File: rtl/lbp_scan_ctrl.sv
// Raster-scan sequencer for the 3x3 LBP window pipeline: issues pixel reads,
// paces the line buffers and flags complete interior windows.
module lbp_scan_ctrl
  import lbp_scan_ctrl_pkg::*;
#(
  parameter int unsigned IMG_W   = DEF_IMG_W,
  parameter int unsigned IMG_H   = DEF_IMG_H,
  parameter int unsigned ADDR_W  = DEF_ADDR_W,
  parameter int unsigned WIN_LAT = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              gray_ready,
  input  logic              hold,
  output logic              gray_req,
  output logic [ADDR_W-1:0] gray_addr,
  output logic              lb_en,
  output logic              out_valid,
  output logic [ADDR_W-1:0] out_addr,
  output logic              finish
);

  localparam int unsigned CW = $clog2(IMG_W);
  localparam int unsigned RW = $clog2(IMG_H);
  localparam int unsigned FW = $clog2(WIN_LAT + 2);
  localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);

  state_t            state, state_nx;
  logic [CW-1:0]     col;
  logic [RW-1:0]     row;
  logic              issue, col_wrap, col_clr, last_px;
  logic [FW-1:0]     flush_cnt;
  logic [RW-1:0]     pix_row;
  logic [CW-1:0]     pix_col;
  logic              cand_vld;
  logic [ADDR_W-1:0] cand_addr;
  logic [WIN_LAT-1:0] vld_pipe;
  logic [ADDR_W-1:0] addr_pipe [WIN_LAT];

  assign issue     = (state == ST_SCAN) && !hold;
  assign col_wrap  = issue && (col == COL_LAST);
  assign col_clr   = col_wrap || (state == ST_IDLE);
  assign last_px   = col_wrap && (row == ROW_LAST);
  assign gray_req  = issue;
  assign gray_addr = ADDR_W'({row, col});
  assign finish    = (state == ST_DONE);

  up_counter #(.W(CW)) u_col (
    .clk   (clk),
    .rst   (rst),
    .en    (issue),
    .clr   (col_clr),
    .count (col)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      row <= '0;
    else if ((state == ST_IDLE) || last_px)
      row <= '0;
    else if (col_wrap)
      row <= row + RW'(1);
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      ST_IDLE:  if (gray_ready) state_nx = ST_SCAN;
      ST_SCAN:  if (last_px) state_nx = ST_FLUSH;
      ST_FLUSH: if (flush_cnt == FW'(WIN_LAT)) state_nx = ST_DONE;
      ST_DONE:  state_nx = ST_IDLE;
      default:  state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= ST_IDLE;
      flush_cnt <= '0;
    end else begin
      state     <= state_nx;
      flush_cnt <= (state == ST_FLUSH) ? flush_cnt + FW'(1) : '0;
    end
  end

  // Coordinates ride with the read so they line up with gray_data on lb_en.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      lb_en   <= 1'b0;
      pix_row <= '0;
      pix_col <= '0;
    end else begin
      lb_en <= issue;
      if (issue) begin
        pix_row <= row;
        pix_col <= col;
      end
    end
  end

  // Pixel (r,c) closes the window centred on (r-1,c-1); interior iff r,c >= 2.
  assign cand_vld  = lb_en && (pix_row >= RW'(2)) && (pix_col >= CW'(2));
  assign cand_addr = ADDR_W'({pix_row - RW'(1), pix_col - CW'(1)});

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vld_pipe  <= '0;
      addr_pipe <= '{default: '0};
    end else begin
      vld_pipe[0] <= cand_vld;
      if (cand_vld)
        addr_pipe[0] <= cand_addr;
      for (int unsigned i = 1; i < WIN_LAT; i++) begin
        vld_pipe[i] <= vld_pipe[i-1];
        if (vld_pipe[i-1])
          addr_pipe[i] <= addr_pipe[i-1];
      end
    end
  end

  assign out_valid = vld_pipe[WIN_LAT-1];
  assign out_addr  = addr_pipe[WIN_LAT-1];

endmodule

// File: tb/tb_lbp_scan_ctrl.sv
// Directed bench for lbp_scan_ctrl: 8x8 instance for ordering/stall/boundary
// cases, default 128x128 instance for full-scan and mid-scan reset.
module tb_lbp_scan_ctrl;

  localparam int unsigned SW = 8, SH = 8, LAT = 2;

  logic clk = 1'b0;
  logic rst;
  logic ready_s, hold_s, ready_b, hold_b;
  logic req_s, lb_s, ov_s, fin_s;
  logic req_b, lb_b, ov_b, fin_b;
  logic [5:0]  ga_s, oa_s;
  logic [13:0] ga_b, oa_b;

  int unsigned cyc = 0;
  int unsigned n_chk = 0, n_fail = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  lbp_scan_ctrl #(.IMG_W(SW), .IMG_H(SH), .ADDR_W(6), .WIN_LAT(LAT)) dut (
    .clk(clk), .rst(rst), .gray_ready(ready_s), .hold(hold_s),
    .gray_req(req_s), .gray_addr(ga_s), .lb_en(lb_s),
    .out_valid(ov_s), .out_addr(oa_s), .finish(fin_s)
  );

  lbp_scan_ctrl dut_big (
    .clk(clk), .rst(rst), .gray_ready(ready_b), .hold(hold_b),
    .gray_req(req_b), .gray_addr(ga_b), .lb_en(lb_b),
    .out_valid(ov_b), .out_addr(oa_b), .finish(fin_b)
  );

  // Small-instance event log
  int unsigned rq_a[$], rq_c[$], lb_c[$], ov_a[$], ov_c[$], fin_c[$];
  always @(negedge clk) begin
    if (req_s) begin rq_a.push_back(ga_s); rq_c.push_back(cyc); end
    if (lb_s)  lb_c.push_back(cyc);
    if (ov_s)  begin ov_a.push_back(oa_s); ov_c.push_back(cyc); end
    if (fin_s) fin_c.push_back(cyc);
  end

  // Large-instance running tallies against the expected raster sequence
  int unsigned b_req, b_req_err, b_ov, b_ov_err, b_fin;
  int unsigned b_req_c0, b_ov_c0, b_fin_c, b_ov_first, b_ov_last;
  always @(negedge clk) begin
    if (req_b) begin
      if (b_req == 0) b_req_c0 = cyc;
      if (ga_b != 14'(b_req)) b_req_err++;
      b_req++;
    end
    if (ov_b) begin
      if (b_ov == 0) begin b_ov_c0 = cyc; b_ov_first = oa_b; end
      if (oa_b != 14'((1 + b_ov / 126) * 128 + 1 + b_ov % 126)) b_ov_err++;
      b_ov_last = oa_b;
      b_ov++;
    end
    if (fin_b) begin b_fin++; b_fin_c = cyc; end
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic clear_log();
    rq_a.delete(); rq_c.delete(); lb_c.delete();
    ov_a.delete(); ov_c.delete(); fin_c.delete();
  endtask

  task automatic check_small_scan(input string tag, input bit no_hold);
    int unsigned e_req = 0, e_lb = 0, e_ov = 0, e_bnd = 0;
    check_eq({tag, "/req_n"}, rq_a.size(), SW * SH);
    check_eq({tag, "/lb_n"}, lb_c.size(), rq_a.size());
    check_eq({tag, "/ov_n"}, ov_a.size(), (SW - 2) * (SH - 2));
    check_eq({tag, "/fin_n"}, fin_c.size(), 1);
    for (int i = 0; i < rq_a.size(); i++) begin
      if (rq_a[i] != i) e_req++;
      if (no_hold && rq_c[i] != rq_c[0] + i) e_req++;
      if (i < lb_c.size() && lb_c[i] != rq_c[i] + 1) e_lb++;
    end
    for (int i = 0; i < ov_a.size(); i++) begin
      int unsigned r = 1 + i / (SW - 2);
      int unsigned c = 1 + i % (SW - 2);
      int unsigned px = (r + 1) * SW + c + 1;
      if (ov_a[i] != r * SW + c) e_ov++;
      if (px >= lb_c.size() || ov_c[i] != lb_c[px] + LAT) e_ov++;
    end
    for (int p = 0; p < lb_c.size(); p++)
      if (p / SW < 2 || p % SW < 2)
        foreach (ov_c[j]) if (ov_c[j] == lb_c[p] + LAT) e_bnd++;
    check_eq({tag, "/req_seq"}, e_req, 0);
    check_eq({tag, "/lb_lat"}, e_lb, 0);
    check_eq({tag, "/ov_seq"}, e_ov, 0);
    check_eq({tag, "/boundary"}, e_bnd, 0);
    if (fin_c.size() > 0 && ov_c.size() > 0)
      check_eq({tag, "/fin_cyc"}, fin_c[0], ov_c[ov_c.size()-1] + 1);
  endtask

  task automatic run_small(input string tag, input int unsigned hold_pct, input bit tog_ready);
    int unsigned t = 0;
    clear_log();
    ready_s = 1'b1;
    @(posedge clk); #1;
    ready_s = 1'b0;
    while (fin_c.size() == 0 && t < 600) begin
      hold_s = ($urandom_range(99) < hold_pct);
      if (tog_ready) ready_s = (t < 40) ? 1'($urandom_range(1)) : 1'b0;
      @(posedge clk); #1;
      t++;
    end
    hold_s = 1'b0; ready_s = 1'b0;
    if (fin_c.size() == 0) check_eq({tag, "/finish_timeout"}, 0, 1);
    repeat (3) @(posedge clk);
    #1;
    check_small_scan(tag, hold_pct == 0);
  endtask

  initial begin
    int unsigned t;
    bit found;
    rst = 1'b0;
    ready_s = 1'b0; hold_s = 1'b0; ready_b = 1'b0; hold_b = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst/small_outs", {req_s, lb_s, ov_s, fin_s, ga_s, oa_s}, 0);
    check_eq("rst/big_outs", {req_b, lb_b, ov_b, fin_b, ga_b, oa_b}, 0);
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    run_small("plain", 0, 1'b0);
    run_small("hold30", 30, 1'b0);
    run_small("rdy_tog", 0, 1'b1);

    // gray_ready held through DONE: back-to-back scans
    clear_log();
    ready_s = 1'b1;
    t = 0;
    while (fin_c.size() < 1 && t < 300) begin @(posedge clk); #1; t++; end
    @(posedge clk); #1;
    ready_s = 1'b0;
    t = 0;
    while (fin_c.size() < 2 && t < 300) begin @(posedge clk); #1; t++; end
    check_eq("held/fin_n", fin_c.size(), 2);
    check_eq("held/req_n", rq_a.size(), 2 * SW * SH);
    if (rq_a.size() > SW * SH && fin_c.size() > 0) begin
      check_eq("held/restart_addr", rq_a[SW*SH], 0);
      check_eq("held/restart_cyc", rq_c[SW*SH], fin_c[0] + 2);
    end

    // Mid-scan asynchronous reset on the full-size instance
    ready_b = 1'b1;
    @(posedge clk); #1;
    ready_b = 1'b0;
    found = 1'b0;
    t = 0;
    while (!found && t < 1000) begin
      @(negedge clk);
      if (req_b && ga_b == 14'd300) found = 1'b1;
      t++;
    end
    check_eq("arst/reach_300", found, 1);
    #1 rst = 1'b0;
    #1;
    check_eq("arst/outs_zero", {req_b, lb_b, ov_b, fin_b, ga_b, oa_b}, 0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    b_req = 0; b_req_err = 0; b_ov = 0; b_ov_err = 0; b_fin = 0;
    repeat (10) @(posedge clk);
    #1;
    check_eq("arst/idle_no_req", b_req, 0);

    // Full default-size scan
    ready_b = 1'b1;
    @(posedge clk); #1;
    ready_b = 1'b0;
    t = 0;
    while (b_fin == 0 && t < 17000) begin @(posedge clk); #1; t++; end
    if (b_fin == 0) check_eq("big/finish_timeout", 0, 1);
    repeat (3) @(posedge clk);
    #1;
    check_eq("big/req_n", b_req, 16384);
    check_eq("big/req_seq", b_req_err, 0);
    check_eq("big/ov_n", b_ov, 15876);
    check_eq("big/ov_seq", b_ov_err, 0);
    check_eq("big/ov_first", b_ov_first, 129);
    check_eq("big/ov_last", b_ov_last, 16254);
    check_eq("big/ov_first_cyc", b_ov_c0 - b_req_c0, 258 + 1 + LAT);
    check_eq("big/fin_n", b_fin, 1);
    check_eq("big/fin_cyc", b_fin_c - b_req_c0, 16383 + 1 + LAT + 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
